xgriscv_fetch_queue: RTL and testbench

- Parametrised instruction-fetch stage with a prefetch FIFO for the pipelined xg-riscv core.
- Drives the fetch PC to the combinational instruction memory and captures {pc, instr} pairs into a DEPTH-entry queue.
- Presents the queue head to decode over a valid/ready handshake.
- Decouples imem from decode stalls and supports a one-cycle redirect (branch, jump, flush) from later stages.

---
 rtl/xgriscv_fetch_queue_if.sv | 30 +++
 rtl/xgriscv_fetch_queue.sv | 110 +++++++++++
 tb/tb_xgriscv_fetch_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xgriscv_fetch_queue_if.sv
// Fetch-queue bus: imem fetch port, redirect input and decode-side valid/ready head.
// master = the fetch queue, slave = the imem/decode/execute environment around it.
interface xgriscv_fetch_queue_if #(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_SIZE-1:0]  pcF;
  logic [INSTR_SIZE-1:0] instrF;
  logic                  redirect;
  logic [ADDR_SIZE-1:0]  redirect_pc;
  logic                  validD;
  logic                  readyD;
  logic [INSTR_SIZE-1:0] instrD;
  logic [ADDR_SIZE-1:0]  pcD;
  logic                  predtakenD;
  logic [CW-1:0]         count;

  modport master (
    output pcF, validD, instrD, pcD, predtakenD, count,
    input  instrF, redirect, redirect_pc, readyD
  );

  modport slave (
    input  pcF, validD, instrD, pcD, predtakenD, count,
    output instrF, redirect, redirect_pc, readyD
  );
endinterface

// File: rtl/xgriscv_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue and one-cycle redirect.
// Optional JAL predecode/prediction is enabled by defining XGRISCV_FQ_JALPRED_EN.
module xgriscv_fetch_queue #(
  parameter int unsigned          ADDR_SIZE  = 32,
  parameter int unsigned          INSTR_SIZE = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
  input logic                   clk,
  input logic                   reset,
  xgriscv_fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_SIZE-1:0]  r_pc_f;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [ADDR_SIZE-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_SIZE-1:0] r_instr_mem [DEPTH];
  logic                  r_pred_mem  [DEPTH];

  logic                 w_valid;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_pred;
  logic [ADDR_SIZE-1:0] w_pc_plus4;
  logic [ADDR_SIZE-1:0] w_next_pc;
  logic [CW-1:0]        w_count_next;

  assign w_valid    = (r_count != '0);
  // Full test on registered count only: a same-cycle dequeue does not free a slot.
  assign w_enq      = !bus.redirect && (r_count < CW'(DEPTH));
  assign w_deq      = !bus.redirect && w_valid && bus.readyD;
  assign w_pc_plus4 = r_pc_f + ADDR_SIZE'(4);

`ifdef XGRISCV_FQ_JALPRED_EN
  logic                 w_is_jal;
  logic [ADDR_SIZE-1:0] w_jal_imm;

  assign w_is_jal  = (bus.instrF[6:0] == 7'b1101111);
  assign w_jal_imm = {{(ADDR_SIZE-21){bus.instrF[31]}}, bus.instrF[31], bus.instrF[19:12],
                      bus.instrF[20], bus.instrF[30:21], 1'b0};
  assign w_pred    = w_is_jal;
  assign w_next_pc = w_is_jal ? (r_pc_f + w_jal_imm) : w_pc_plus4;
`else
  assign w_pred    = 1'b0;
  assign w_next_pc = w_pc_plus4;
`endif

  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_deq) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_enq && w_deq) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f  <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_pc_f  <= bus.redirect_pc;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_pc_f <= w_next_pc;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
        r_pred_mem[i]  <= 1'b0;
      end
    end else if (w_enq) begin
      r_pc_mem[r_wptr]    <= r_pc_f;
      r_instr_mem[r_wptr] <= bus.instrF;
      r_pred_mem[r_wptr]  <= w_pred;
    end
  end

  assign bus.pcF    = r_pc_f;
  assign bus.count  = r_count;
  assign bus.validD = w_valid;
  assign bus.pcD    = r_pc_mem[r_rptr];
  assign bus.instrD = r_instr_mem[r_rptr];
`ifdef XGRISCV_FQ_JALPRED_EN
  assign bus.predtakenD = r_pred_mem[r_rptr];
`else
  assign bus.predtakenD = 1'b0;
`endif

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Directed bench for xgriscv_fetch_queue: reset, streaming, stall/full, redirects, JAL prediction.
module tb_xgriscv_fetch_queue;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned DP = 4;
  localparam logic [31:0] JalWord = 32'h0400_006F;  // jal x0, +0x40
`ifdef XGRISCV_FQ_JALPRED_EN
  localparam bit JalPred = 1'b1;
`else
  localparam bit JalPred = 1'b0;
`endif

  logic clk;
  logic reset;
  bit   jal_en;
  int   n_total;
  int   n_bad;

  xgriscv_fetch_queue_if #(.ADDR_SIZE(AW), .INSTR_SIZE(IW), .DEPTH(DP)) bus ();

  xgriscv_fetch_queue #(
    .ADDR_SIZE (AW),
    .INSTR_SIZE(IW),
    .DEPTH     (DP),
    .RESET_PC  (32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational imem: distinct non-JAL word per address, optional JAL at 0x8.
  always_comb begin
    if (jal_en && bus.pcF == 32'h8) bus.instrF = JalWord;
    else                            bus.instrF = {bus.pcF[29:0], 2'b11};
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {pc[29:0], 2'b11};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rdy);
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.readyD      = rdy;
    reset           = 1'b1;
    tick();
    reset           = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    bus.redirect = 1'b0;
    bus.readyD   = 1'b1;
    reset        = 1'b1;
    #2;
    n_total++; if (bus.pcF !== 32'h0) begin n_bad++; $display("FAIL reset_pcF got=%0h want=0", bus.pcF); end
    n_total++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    n_total++; if (bus.validD !== 1'b0) begin n_bad++; $display("FAIL reset_validD got=%b want=0", bus.validD); end
    n_total++; if (bus.pcD !== 32'h0 || bus.instrD !== 32'h0 || bus.predtakenD !== 1'b0) begin
      n_bad++; $display("FAIL reset_head got pc=%0h instr=%0h pt=%b want 0/0/0", bus.pcD, bus.instrD,
                        bus.predtakenD);
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_pc = 32'(4 * (k - 1));
      n_total++; if (bus.pcF !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_pcF k=%0d got=%0h want=%0h", k, bus.pcF, 4 * k); end
      n_total++; if (bus.validD !== 1'b1 || bus.pcD !== exp_pc || bus.instrD !== word_at(exp_pc)) begin
        n_bad++; $display("FAIL stream_head k=%0d got v=%b pc=%0h i=%0h want v=1 pc=%0h i=%0h", k,
                          bus.validD, bus.pcD, bus.instrD, exp_pc, word_at(exp_pc));
      end
      n_total++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL stream_count k=%0d got=%0d want=1", k, bus.count); end
    end
  endtask

  task automatic test_stall();
    start(1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 4) begin
        n_total++; if (bus.count !== 3'(k)) begin n_bad++; $display("FAIL stall_count k=%0d got=%0d want=%0d", k, bus.count, k); end
      end
    end
    n_total++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d want=4", bus.count); end
    n_total++; if (bus.pcF !== 32'h10) begin n_bad++; $display("FAIL full_pcF got=%0h want=10", bus.pcF); end
    bus.readyD = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      n_total++; if (bus.validD !== 1'b1 || bus.pcD !== 32'(4 * k)) begin
        n_bad++; $display("FAIL drain_pcD k=%0d got v=%b pc=%0h want v=1 pc=%0h", k, bus.validD, bus.pcD, 4 * k);
      end
      if (k == 1) begin
        n_total++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL drain_count got=%0d want=3", bus.count); end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    start(1'b0);
    for (int k = 0; k < 3; k++) tick();
    n_total++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL redir_pre_count got=%0d want=3", bus.count); end
    bus.readyD      = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    n_total++; if (bus.count !== 3'd0 || bus.validD !== 1'b0 || bus.pcF !== 32'h100) begin
      n_bad++; $display("FAIL redir_flush got c=%0d v=%b pcF=%0h want c=0 v=0 pcF=100", bus.count,
                        bus.validD, bus.pcF);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_total++; if (bus.validD !== 1'b1 || bus.pcD !== 32'h100 + 32'(4 * k)) begin
        n_bad++; $display("FAIL redir_seq k=%0d got v=%b pc=%0h want v=1 pc=%0h", k, bus.validD,
                          bus.pcD, 32'h100 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_back_to_back();
    start(1'b1);
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    n_total++; if (bus.pcF !== 32'h200) begin n_bad++; $display("FAIL b2b_first_pcF got=%0h want=200", bus.pcF); end
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    n_total++; if (bus.pcF !== 32'h300 || bus.validD !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second got pcF=%0h v=%b want pcF=300 v=0", bus.pcF, bus.validD);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (bus.validD !== 1'b1 || bus.pcD !== 32'h300 + 32'(4 * k)) begin
        n_bad++; $display("FAIL b2b_seq k=%0d got v=%b pc=%0h want v=1 pc=%0h", k, bus.validD,
                          bus.pcD, 32'h300 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_reset_mid();
    start(1'b0);
    tick();
    tick();
    n_total++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL midrst_pre_count got=%0d want=2", bus.count); end
    reset = 1'b1;
    #1;
    n_total++; if (bus.validD !== 1'b0 || bus.count !== 3'd0 || bus.pcF !== 32'h0) begin
      n_bad++; $display("FAIL midrst_async got v=%b c=%0d pcF=%0h want v=0 c=0 pcF=0", bus.validD,
                        bus.count, bus.pcF);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_jal();
    logic [31:0] exp_pcd [4];
    logic        exp_pt  [4];
    exp_pcd = '{32'h0, 32'h4, 32'h8, JalPred ? 32'h48 : 32'hC};
    exp_pt  = '{1'b0, 1'b0, JalPred, 1'b0};
    jal_en  = 1'b1;
    start(1'b1);
    tick();
    tick();
    tick();
    n_total++; if (bus.pcF !== (JalPred ? 32'h48 : 32'hC)) begin
      n_bad++; $display("FAIL jal_pcF got=%0h want=%0h", bus.pcF, JalPred ? 32'h48 : 32'hC);
    end
    n_total++; if (bus.instrD !== JalWord) begin n_bad++; $display("FAIL jal_instrD got=%0h want=%0h", bus.instrD, JalWord); end
    start(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (bus.pcD !== exp_pcd[k] || bus.predtakenD !== exp_pt[k]) begin
        n_bad++; $display("FAIL jal_seq k=%0d got pc=%0h pt=%b want pc=%0h pt=%b", k, bus.pcD,
                          bus.predtakenD, exp_pcd[k], exp_pt[k]);
      end
    end
    jal_en = 1'b0;
  endtask

  initial begin
    n_total         = 0;
    n_bad           = 0;
    jal_en          = 1'b0;
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.readyD      = 1'b0;
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_jal();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
